ccg_truth_table_sweeper: RTL and testbench

// - Exhaustive stimulus/capture stage wrapped around one generated combinational CCG netlist (x* in, f* out).
// - Drives every input vector 0..2^N_IN-1 onto the netlist, samples all outputs, then streams one truth table per output.
// - Feeds the AIG dataset labelling path; the netlist under test stays purely combinational.

---
 rtl/ccg_truth_table_sweeper_pkg.sv | 19 +
 rtl/ccg_truth_table_sweeper_if.sv | 30 +++
 rtl/ccg_truth_table_sweeper_capture_buf.sv | 34 +++
 rtl/ccg_truth_table_sweeper.sv | 131 +++++++++++++
 tb/tb_ccg_truth_table_sweeper.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ccg_truth_table_sweeper_pkg.sv
// Shared constants for the CCG truth-table sweeper: default geometry, FSM encodings
// and a width helper that never returns zero.
package ccg_tt_pkg;
  localparam int N_IN_DEF   = 3;
  localparam int N_OUT_DEF  = 8;
  localparam int SETTLE_DEF = 1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int N_VEC = 1 << N_IN_DEF;
  localparam int IDX_W = clog2_min1(N_OUT_DEF);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_EMIT   = 2'd3;
endpackage

// File: rtl/ccg_truth_table_sweeper_if.sv
// Sweep control, netlist stimulus/response and truth-table stream bundled as one port.
interface ccg_tt_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 8
);
  import ccg_tt_pkg::*;
  localparam int IW = clog2_min1(N_OUT);
  localparam int NV = 1 << N_IN;

  logic            start;
  logic            busy;
  logic [N_IN-1:0] dut_x;
  logic [N_OUT-1:0] dut_f;
  logic            tt_valid;
  logic            tt_ready;
  logic [IW-1:0]   tt_idx;
  logic [NV-1:0]   tt_data;
  logic            tt_last;
  logic            done;

  modport master (
    input  start, dut_f, tt_ready,
    output busy, dut_x, tt_valid, tt_idx, tt_data, tt_last, done
  );

  modport slave (
    output start, dut_f, tt_ready,
    input  busy, dut_x, tt_valid, tt_idx, tt_data, tt_last, done
  );
endinterface

// File: rtl/ccg_truth_table_sweeper_capture_buf.sv
// Capture store: one column (all outputs for a vector) written per sample,
// one row (full truth table of one output) read per emitted beat.
module ccg_tt_capture_buf #(
  parameter int N_OUT = 8,
  parameter int N_VEC = 8,
  parameter int IDX_W = 3,
  parameter int COL_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [COL_W-1:0] i_col,
  input  logic [N_OUT-1:0] i_din,
  input  logic [IDX_W-1:0] i_row,
  output logic [N_VEC-1:0] o_row
);
  logic [N_VEC-1:0] r_mem [N_OUT];

  // Column write of every output bit at the sampled vector position.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_OUT; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      for (int k = 0; k < N_OUT; k++) r_mem[k][i_col] <= i_din[k];
    end else begin
      for (int k = 0; k < N_OUT; k++) r_mem[k] <= r_mem[k];
    end
  end

  // Row read of the table currently being streamed.
  always_comb begin
    o_row = r_mem[i_row];
  end
endmodule

// File: rtl/ccg_truth_table_sweeper.sv
// Exhaustive sweeper: walks every input vector through a combinational netlist,
// captures all outputs, then streams one truth table per output over valid/ready.
module ccg_truth_table_sweeper
  import ccg_tt_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic     i_clk,
  input  logic     i_rst,
  ccg_tt_if.master io_bus
);
  localparam int VEC_N = 1 << N_IN;
  localparam int IW    = clog2_min1(N_OUT);
  localparam int SW    = clog2_min1(SETTLE + 1);
  localparam int VW    = N_IN + 1;

  logic [1:0]      r_state;
  logic [VW-1:0]   r_vec;
  logic [SW-1:0]   r_settle;
  logic [IW-1:0]   r_idx;
  logic            r_busy;
  logic [N_IN-1:0] r_dut_x;
  logic            r_valid;
  logic            r_last;
  logic            r_done;
  logic            w_we;
  logic [VEC_N-1:0] w_row;

  ccg_tt_capture_buf #(
    .N_OUT (N_OUT),
    .N_VEC (VEC_N),
    .IDX_W (IW),
    .COL_W (N_IN)
  ) u_buf (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_we  (w_we),
    .i_col (r_vec[N_IN-1:0]),
    .i_din (io_bus.dut_f),
    .i_row (r_idx),
    .o_row (w_row)
  );

  // Capture happens only in the single SAMPLE cycle of each vector.
  always_comb begin
    w_we = (r_state == ST_SAMPLE);
  end

  // Sweep FSM; a start coinciding with the done pulse is deliberately dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_vec    <= '0;
      r_settle <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_dut_x  <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_bus.start && !r_done) begin
            r_state  <= ST_DRIVE;
            r_busy   <= 1'b1;
            r_vec    <= '0;
            r_settle <= '0;
            r_dut_x  <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (r_settle == SW'(SETTLE)) begin
            r_settle <= '0;
            r_state  <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (r_vec == VW'(VEC_N - 1)) begin
            r_state <= ST_EMIT;
            r_valid <= 1'b1;
            r_idx   <= '0;
            r_last  <= (N_OUT == 1) ? 1'b1 : 1'b0;
            r_dut_x <= '0;
          end else begin
            r_vec   <= r_vec + 1'b1;
            r_dut_x <= r_vec[N_IN-1:0] + 1'b1;
            r_state <= ST_DRIVE;
          end
        end
        ST_EMIT: begin
          if (io_bus.tt_ready) begin
            if (r_last) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx  <= r_idx + 1'b1;
              r_last <= (r_idx == IW'(N_OUT - 2));
            end
          end else begin
            r_idx <= r_idx;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Payload is a register-file row; gated so it reads zero whenever no beat is offered.
  always_comb begin
    io_bus.busy     = r_busy;
    io_bus.dut_x    = r_dut_x;
    io_bus.tt_valid = r_valid;
    io_bus.tt_idx   = r_idx;
    io_bus.tt_last  = r_last;
    io_bus.done     = r_done;
    if (r_valid) io_bus.tt_data = w_row;
    else         io_bus.tt_data = '0;
  end
endmodule

// File: tb/tb_ccg_truth_table_sweeper.sv
// Directed bench: table of expected truth tables per netlist model, plus
// stall, restart, SETTLE=0 latency and reset-abort sequences.
module tb_ccg_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ccg_tt_if #(.N_IN(3), .N_OUT(8)) bus1 ();
  ccg_tt_if #(.N_IN(3), .N_OUT(8)) bus0 ();

  ccg_truth_table_sweeper #(.N_IN(3), .N_OUT(8), .SETTLE(1)) dut1 (
    .i_clk (clk), .i_rst (rst), .io_bus (bus1)
  );
  ccg_truth_table_sweeper #(.N_IN(3), .N_OUT(8), .SETTLE(0)) dut0 (
    .i_clk (clk), .i_rst (rst), .io_bus (bus0)
  );

  int model_sel = 0;

  function automatic logic [7:0] model_f(input int m, input logic [2:0] x);
    case (m)
      0:       return 8'd1 << x;
      1:       return 8'hA5;
      2:       return {6'd0, x[0] ^ x[2], x[0] & x[1]};
      default: return 8'h00;
    endcase
  endfunction

  always_comb bus1.dut_f = model_f(model_sel, bus1.dut_x);
  always_comb bus0.dut_f = model_f(model_sel, bus0.dut_x);

  typedef struct {
    int         model;
    int         k;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt [24];
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] cap_data [8];
  logic [2:0] cap_idx  [8];
  logic       cap_last [8];
  int n_beats;
  int lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_cap();
    for (int j = 0; j < 8; j++) begin
      cap_data[j] = 'x;
      cap_idx[j]  = 'x;
      cap_last[j] = 1'bx;
    end
    n_beats = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  bus1.busy, 0);
    chk({tag, "_dut_x"}, bus1.dut_x, 0);
    chk({tag, "_valid"}, bus1.tt_valid, 0);
    chk({tag, "_idx"},   bus1.tt_idx, 0);
    chk({tag, "_data"},  bus1.tt_data, 0);
    chk({tag, "_last"},  bus1.tt_last, 0);
    chk({tag, "_done"},  bus1.done, 0);
  endtask

  task automatic check_tables(input int mdl);
    chk("beat_count", n_beats, 8);
    for (int i = 0; i < 24; i++) begin
      if (vt[i].model == mdl) begin
        chk("tt_data", cap_data[vt[i].k], vt[i].exp_data);
        chk("tt_idx",  cap_idx[vt[i].k], vt[i].k);
        chk("tt_last", cap_last[vt[i].k], (vt[i].k == 7) ? 1 : 0);
      end
    end
  endtask

  // Full sweep on the SETTLE=1 instance; rmode 1 gives ready one cycle in three.
  task automatic sweep(input int mdl, input int rmode, input bit restart, input bit done_start);
    int c;
    bit prev_stall;
    logic [2:0] p_idx;
    logic [7:0] p_data;
    model_sel = mdl;
    clear_cap();
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
    lat = 0;
    while (!bus1.tt_valid && lat < 200) begin
      chk("dut_x_seq", bus1.dut_x, lat / 3);
      chk("busy_sweep", bus1.busy, 1);
      bus1.start = (restart && (lat == 10 || lat == 20)) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    bus1.start = 1'b0;
    chk("latency_s1", lat, 24);
    c = 0;
    prev_stall = 1'b0;
    p_idx = '0;
    p_data = '0;
    while (n_beats < 8 && c < 100) begin
      bus1.tt_ready = (rmode == 0) ? 1'b1 : ((c % 3) == 2);
      if (prev_stall) begin
        chk("stall_idx", bus1.tt_idx, p_idx);
        chk("stall_data", bus1.tt_data, p_data);
      end
      if (bus1.tt_valid && bus1.tt_ready) begin
        cap_data[n_beats] = bus1.tt_data;
        cap_idx[n_beats]  = bus1.tt_idx;
        cap_last[n_beats] = bus1.tt_last;
        n_beats++;
      end
      prev_stall = bus1.tt_valid && !bus1.tt_ready;
      p_idx = bus1.tt_idx;
      p_data = bus1.tt_data;
      c++;
      @(negedge clk);
    end
    bus1.tt_ready = 1'b0;
    chk("done_pulse", bus1.done, 1);
    chk("busy_after", bus1.busy, 0);
    chk("valid_after", bus1.tt_valid, 0);
    bus1.start = done_start;
    @(negedge clk);
    bus1.start = 1'b0;
    chk("done_one_cycle", bus1.done, 0);
    chk("start_on_done_ignored", bus1.busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_valid", bus1.tt_valid, 0);
    end
    check_tables(mdl);
  endtask

  initial begin
    logic [7:0] a5;
    int w;
    a5 = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      vt[k]      = '{0, k, 8'd1 << k};
      vt[8 + k]  = '{1, k, a5[k] ? 8'hFF : 8'h00};
      vt[16 + k] = '{2, k, 8'h00};
    end
    vt[16].exp_data = 8'h88;
    vt[17].exp_data = 8'h5A;

    bus1.start = 1'b0; bus1.tt_ready = 1'b0;
    bus0.start = 1'b0; bus0.tt_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("post_rst");

    sweep(0, 0, 1'b0, 1'b0);
    sweep(1, 0, 1'b0, 1'b0);
    sweep(2, 0, 1'b0, 1'b0);
    sweep(0, 1, 1'b1, 1'b1);

    // SETTLE=0 instance: 2 cycles per vector
    model_sel = 1;
    clear_cap();
    @(negedge clk) bus0.start = 1'b1;
    @(negedge clk) bus0.start = 1'b0;
    lat = 0;
    while (!bus0.tt_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency_s0", lat, 16);
    bus0.tt_ready = 1'b1;
    w = 0;
    while (n_beats < 8 && w < 50) begin
      if (bus0.tt_valid) begin
        cap_data[n_beats] = bus0.tt_data;
        cap_idx[n_beats]  = bus0.tt_idx;
        cap_last[n_beats] = bus0.tt_last;
        n_beats++;
      end
      w++;
      @(negedge clk);
    end
    bus0.tt_ready = 1'b0;
    chk("s0_done", bus0.done, 1);
    check_tables(1);

    // reset while vector 4 is being driven
    model_sel = 0;
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
    lat = 0;
    while (lat < 13) begin
      @(negedge clk);
      lat++;
    end
    chk("pre_rst_x", bus1.dut_x, 4);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_vec4");
    rst = 1'b0;
    @(negedge clk);

    // reset after two beats of the emit phase
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
    w = 0;
    while (!bus1.tt_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("emit_reached", bus1.tt_valid, 1);
    bus1.tt_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus1.tt_ready = 1'b0;
    chk("mid_emit_idx", bus1.tt_idx, 2);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_emit");
    rst = 1'b0;
    @(negedge clk);

    sweep(2, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
